// File: rtl/rvh_l1d_snp_req_buf.sv
`default_nettype none
// ============================================================================
// Module   : rvh_l1d_snp_req_buf
// Brief    : In-order ACE snoop request buffer feeding the L1D snoop lookup
//            pipeline and building the CR response. Optional macro
//            RVH_L1D_SNP_BYPASS_EN adds a same-cycle AC->pipeline issue path.
// Revision : 1.0 - initial release
// ============================================================================
module rvh_l1d_snp_req_buf #(
    parameter int N_SNP_ENTRY = 4,
    parameter int LINE_ADDR_W = 34
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   snp_req_if_acvalid_i,
    output logic                   snp_req_if_acready_o,
    input  logic [LINE_ADDR_W-1:0] snp_req_if_acaddr_i,
    input  logic [3:0]             snp_req_if_acsnoop_i,
    input  logic                   snp_stall_i,
    output logic                   snp_pipe_req_valid_o,
    input  logic                   snp_pipe_req_ready_i,
    output logic [LINE_ADDR_W-1:0] snp_pipe_req_line_addr_o,
    output logic                   snp_pipe_req_leave_invalid_o,
    output logic                   snp_pipe_req_leave_sharedclean_o,
    input  logic                   snp_pipe_resp_valid_i,
    input  logic                   snp_pipe_resp_hit_i,
    input  logic                   snp_pipe_resp_dirty_i,
    input  logic                   snp_pipe_resp_unique_i,
    output logic                   snp_resp_if_crvalid_o,
    input  logic                   snp_resp_if_crready_i,
    output logic [4:0]             snp_resp_if_crresp_o,
    output logic                   snp_buf_empty_o
);

    localparam int c_ptr_w = $clog2(N_SNP_ENTRY);
    localparam int c_cnt_w = c_ptr_w + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Decoded entry fields: {leave_invalid, leave_sharedclean, ret_clean, ret_dirty}
    function automatic logic [3:0] f_decode(input logic [3:0] snoop);
        case (snoop)
            4'b0011: f_decode = 4'b0111;
            4'b0111: f_decode = 4'b1011;
            4'b1001: f_decode = 4'b1001;
            default: f_decode = 4'b0111;
        endcase
    endfunction

    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_count;
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [LINE_ADDR_W-1:0] r_addr [N_SNP_ENTRY];
    logic [N_SNP_ENTRY-1:0] r_li;
    logic [N_SNP_ENTRY-1:0] r_lsc;
    logic [N_SNP_ENTRY-1:0] r_rc;
    logic [N_SNP_ENTRY-1:0] r_rdty;
    logic [4:0]             r_crresp;

    logic [3:0]         w_ac_dec;
    logic               w_acready;
    logic               w_push;
    logic               w_pop;
    logic               w_issue_valid;
    logic               w_byp_valid;
    logic               w_byp_fire;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic               w_hd_rc;
    logic               w_hd_rd;
    logic               w_hd_li;
    logic               w_dt;
    logic [4:0]         w_crresp;

    assign w_ac_dec      = f_decode(snp_req_if_acsnoop_i);
    assign w_acready     = (r_count != c_cnt_w'(N_SNP_ENTRY));
    assign w_push        = snp_req_if_acvalid_i && w_acready;
    assign w_pop         = (r_state == S_RESP) && snp_resp_if_crready_i;
    assign w_issue_valid = (r_state == S_ISSUE) && !snp_stall_i;

`ifdef RVH_L1D_SNP_BYPASS_EN
    assign w_byp_valid = (r_count == '0) && (r_state == S_IDLE) &&
                         snp_req_if_acvalid_i && !snp_stall_i;
`else
    assign w_byp_valid = 1'b0;
`endif
    assign w_byp_fire = w_byp_valid && snp_pipe_req_ready_i;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
            2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    assign w_hd_rc  = r_rc[r_rd_ptr];
    assign w_hd_rd  = r_rdty[r_rd_ptr];
    assign w_hd_li  = r_li[r_rd_ptr];
    assign w_dt     = snp_pipe_resp_hit_i &
                      (snp_pipe_resp_dirty_i ? w_hd_rd : w_hd_rc);
    // {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    assign w_crresp = {snp_pipe_resp_hit_i & snp_pipe_resp_unique_i,
                       snp_pipe_resp_hit_i & !w_hd_li,
                       snp_pipe_resp_hit_i & snp_pipe_resp_dirty_i & w_dt,
                       1'b0,
                       w_dt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_li     <= '0;
            r_lsc    <= '0;
            r_rc     <= '0;
            r_rdty   <= '0;
            for (int i = 0; i < N_SNP_ENTRY; i++) begin
                r_addr[i] <= '0;
            end
        end else if (w_push) begin
            r_addr[r_wr_ptr] <= snp_req_if_acaddr_i;
            r_li[r_wr_ptr]   <= w_ac_dec[3];
            r_lsc[r_wr_ptr]  <= w_ac_dec[2];
            r_rc[r_wr_ptr]   <= w_ac_dec[1];
            r_rdty[r_wr_ptr] <= w_ac_dec[0];
            r_wr_ptr         <= r_wr_ptr + c_ptr_w'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_crresp <= '0;
        end else begin
            r_count <= w_count_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_byp_fire) begin
                        r_state <= S_WAIT;
                    end else if (w_push || (r_count != '0)) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue_valid && snp_pipe_req_ready_i) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (snp_pipe_resp_valid_i) begin
                        r_crresp <= w_crresp;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                        // A push landing in the same cycle keeps the buffer busy
                        r_state  <= (w_count_nxt != '0) ? S_ISSUE : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign snp_req_if_acready_o             = w_acready;
    assign snp_pipe_req_valid_o             = w_issue_valid || w_byp_valid;
    assign snp_pipe_req_line_addr_o         = w_byp_valid ? snp_req_if_acaddr_i : r_addr[r_rd_ptr];
    assign snp_pipe_req_leave_invalid_o     = w_byp_valid ? w_ac_dec[3] : r_li[r_rd_ptr];
    assign snp_pipe_req_leave_sharedclean_o = w_byp_valid ? w_ac_dec[2] : r_lsc[r_rd_ptr];
    assign snp_resp_if_crvalid_o            = (r_state == S_RESP);
    assign snp_resp_if_crresp_o             = r_crresp;
    assign snp_buf_empty_o                  = (r_count == '0) && (r_state == S_IDLE);

endmodule
`default_nettype wire
